// File: rtl/bcd_sevenseg_scan.sv
// Time-multiplexed common-anode seven-segment driver for packed BCD digits.
// Digits and decimal points are latched into a shadow register once per frame so the
// visible value never tears. One digit is lit per scan slot, LSD first.
// Optional build macro: LEADING_ZERO_BLANK_EN blanks leading zero digits (digit 0 is kept).
module bcd_sevenseg_scan #(
  parameter int unsigned NUM_DIGITS     = 4,
  parameter int unsigned SCAN_DIV       = 1000,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          AN_ACTIVE_LOW  = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    hold,
  output logic [6:0]              seg,
  output logic                    dp,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_done
);

  localparam int unsigned PresW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned IdxW  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PresW-1:0] PresMax = PresW'(SCAN_DIV - 1);
  localparam logic [IdxW-1:0]  IdxMax  = IdxW'(NUM_DIGITS - 1);

  // Pin levels for "nothing lit" / "no anode enabled".
  localparam logic [6:0]            SegOff = SEG_ACTIVE_LOW ? 7'h7f : 7'h00;
  localparam logic                  DpOff  = SEG_ACTIVE_LOW;
  localparam logic [NUM_DIGITS-1:0] AnOff  = AN_ACTIVE_LOW ? '1 : '0;

  // Active-high abcdefg patterns; seg[6] = a, seg[0] = g.
  function automatic logic [6:0] decode(input logic [3:0] v);
    logic [6:0] p;
    case (v)
      4'd0:    p = 7'b1111110;
      4'd1:    p = 7'b0110000;
      4'd2:    p = 7'b1101101;
      4'd3:    p = 7'b1111001;
      4'd4:    p = 7'b0110011;
      4'd5:    p = 7'b1011011;
      4'd6:    p = 7'b1011111;
      4'd7:    p = 7'b1110000;
      4'd8:    p = 7'b1111111;
      4'd9:    p = 7'b1111011;
      default: p = 7'b0000001; // non-BCD codes show a dash
    endcase
    return p;
  endfunction

  logic [PresW-1:0]        presc_q, presc_d;
  logic [IdxW-1:0]         idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] shadow_bcd_q, shadow_bcd_d;
  logic [NUM_DIGITS-1:0]   shadow_dp_q, shadow_dp_d;
  logic                    frame_done_q;
  logic [6:0]              seg_q, seg_d;
  logic                    dp_q, dp_d;
  logic [NUM_DIGITS-1:0]   an_q, an_d;

  logic                    tick;
  logic                    capture;
  logic [3:0]              digits [NUM_DIGITS];
  logic [3:0]              cur_digit;
  logic [NUM_DIGITS-1:0]   blank;

  // Slot timing: prescaler wraps at SCAN_DIV-1, digit index advances once per slot.
  always_comb begin
    tick    = (presc_q == PresMax);
    presc_d = tick ? '0 : presc_q + PresW'(1);
    idx_d   = idx_q;
    if (tick) begin
      idx_d = (idx_q == IdxMax) ? '0 : idx_q + IdxW'(1);
    end
    capture = tick && (idx_q == IdxMax) && !hold;
  end

  // Shadow load happens only at the end of the last slot of a frame.
  always_comb begin
    shadow_bcd_d = shadow_bcd_q;
    shadow_dp_d  = shadow_dp_q;
    if (capture) begin
      shadow_bcd_d = bcd_in;
      shadow_dp_d  = dp_in;
    end
  end

  // Unpack the shadow into per-digit nibbles and pick the one for the current slot.
  always_comb begin
    for (int i = 0; i < int'(NUM_DIGITS); i++) begin
      digits[i] = shadow_bcd_q[4*i +: 4];
    end
    cur_digit = digits[idx_q];
  end

`ifdef LEADING_ZERO_BLANK_EN
  // A digit is blank when it and every digit above it are zero; digit 0 always shows.
  always_comb begin
    logic nz_seen;
    nz_seen = 1'b0;
    blank   = '0;
    for (int i = int'(NUM_DIGITS) - 1; i >= 1; i--) begin
      nz_seen  = nz_seen | (digits[i] != 4'd0);
      blank[i] = !nz_seen;
    end
  end
`else
  // Every digit is decoded, leading zeros included.
  always_comb begin
    blank = '0;
  end
`endif

  // Next-cycle pin values for the current slot, polarity applied after decode.
  always_comb begin
    logic [6:0]            seg_raw;
    logic [NUM_DIGITS-1:0] an_raw;
    seg_raw = decode(cur_digit);
    if (blank[idx_q]) begin
      seg_raw = '0;
    end
    an_raw        = '0;
    an_raw[idx_q] = 1'b1;
    seg_d = SEG_ACTIVE_LOW ? ~seg_raw : seg_raw;
    dp_d  = SEG_ACTIVE_LOW ? ~shadow_dp_q[idx_q] : shadow_dp_q[idx_q];
    an_d  = AN_ACTIVE_LOW ? ~an_raw : an_raw;
  end

  // State and output registers with synchronous reset taking priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q      <= '0;
      idx_q        <= '0;
      shadow_bcd_q <= '0;
      shadow_dp_q  <= '0;
      frame_done_q <= 1'b0;
      seg_q        <= SegOff;
      dp_q         <= DpOff;
      an_q         <= AnOff;
    end else begin
      presc_q      <= presc_d;
      idx_q        <= idx_d;
      shadow_bcd_q <= shadow_bcd_d;
      shadow_dp_q  <= shadow_dp_d;
      frame_done_q <= capture;
      seg_q        <= seg_d;
      dp_q         <= dp_d;
      an_q         <= an_d;
    end
  end

  assign seg        = seg_q;
  assign dp         = dp_q;
  assign an         = an_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_sevenseg_scan.sv
// Self-checking bench for bcd_sevenseg_scan (NUM_DIGITS=4, SCAN_DIV=4, active-low pins).
// Honours LEADING_ZERO_BLANK_EN when the build defines it.
module tb_bcd_sevenseg_scan;

  localparam int N = 4;
  localparam int D = 4;
  localparam int F = N * D;

  // Active-high abcdefg per digit value; 10..15 are a dash.
  localparam logic [6:0] PAT [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011, 7'b1011011,
    7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011, 7'b0000001, 7'b0000001,
    7'b0000001, 7'b0000001, 7'b0000001, 7'b0000001
  };

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] bcd_in = 16'h0000;
  logic [3:0]  dp_in = 4'b0000;
  logic        hold = 1'b0;
  logic [6:0]  seg;
  logic        dp;
  logic [3:0]  an;
  logic        frame_done;

  int total = 0;
  int bad = 0;

  bcd_sevenseg_scan #(
    .NUM_DIGITS    (N),
    .SCAN_DIV      (D),
    .SEG_ACTIVE_LOW(1'b1),
    .AN_ACTIVE_LOW (1'b1)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .bcd_in    (bcd_in),
    .dp_in     (dp_in),
    .hold      (hold),
    .seg       (seg),
    .dp        (dp),
    .an        (an),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  // Model: k = clock edges since the last reset edge; a frame captures on every edge with
  // k a multiple of F (hold low). Outputs after edge k show the shadow as it was after k-1.
  int          m_k = 0;
  bit          m_valid = 1'b0;
  logic [15:0] m_sh = '0, m_disp = '0;
  logic [3:0]  m_shdp = '0, m_dispdp = '0;
  logic        m_fd = 1'b0;

  always @(posedge clk) begin
    if (rst) begin
      m_valid  <= 1'b1;
      m_k      <= 0;
      m_sh     <= '0;
      m_shdp   <= '0;
      m_disp   <= '0;
      m_dispdp <= '0;
      m_fd     <= 1'b0;
    end else if (m_valid) begin
      m_k      <= m_k + 1;
      m_disp   <= m_sh;
      m_dispdp <= m_shdp;
      if ((m_k + 1) % F == 0 && !hold) begin
        m_sh   <= bcd_in;
        m_shdp <= dp_in;
        m_fd   <= 1'b1;
      end else begin
        m_fd <= 1'b0;
      end
    end
  end

  function automatic logic [6:0] model_seg(input int k, input logic [15:0] disp);
    int         slot;
    logic [6:0] lit;
    if (k == 0) return 7'h7f;
    slot = ((k - 1) / D) % N;
    lit  = PAT[disp[slot*4 +: 4]];
`ifdef LEADING_ZERO_BLANK_EN
    begin
      int msd;
      msd = 0;
      for (int i = 0; i < N; i++) if (disp[i*4 +: 4] != 4'd0) msd = i;
      if (slot > msd) lit = 7'b0000000;
    end
`endif
    return ~lit;
  endfunction

  function automatic logic model_dp(input int k, input logic [3:0] ddp);
    if (k == 0) return 1'b1;
    return ~ddp[((k - 1) / D) % N];
  endfunction

  function automatic logic [3:0] model_an(input int k);
    if (k == 0) return 4'b1111;
    return ~(4'b0001 << (((k - 1) / D) % N));
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at t=%0t k=%0d: got %h want %h", nm, $time, m_k, act, exp);
    end
  endtask

  // Cycle-by-cycle comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (m_valid) begin
      chk("seg", {9'd0, seg}, {9'd0, model_seg(m_k, m_disp)});
      chk("dp", {15'd0, dp}, {15'd0, model_dp(m_k, m_dispdp)});
      chk("an", {12'd0, an}, {12'd0, model_an(m_k)});
      chk("frame_done", {15'd0, frame_done}, {15'd0, m_fd});
    end
  end

  // Advance to the falling edge following the k-th edge after reset.
  task automatic goto(input int k);
    int guard;
    guard = 0;
    if (m_k < k) begin
      while (m_k < k && guard < 1000) begin
        @(posedge clk);
        #1;
        guard++;
      end
      if (m_k < k) chk("goto_bound", 16'(m_k), 16'(k));
      @(negedge clk);
    end
  endtask

  task automatic lit_digit(input int k, input logic [3:0] ean, input logic [6:0] eseg,
                           input logic edp);
    goto(k);
    chk("lit_an", {12'd0, an}, {12'd0, ean});
    chk("lit_seg", {9'd0, seg}, {9'd0, eseg});
    chk("lit_dp", {15'd0, dp}, {15'd0, edp});
  endtask

  task automatic lit_fd(input int k, input logic efd);
    goto(k);
    chk("lit_frame_done", {15'd0, frame_done}, {15'd0, efd});
  endtask

  initial begin
    #50000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset held for three edges.
    repeat (3) @(posedge clk);
    @(negedge clk);
    lit_digit(0, 4'b1111, 7'b1111111, 1'b1);
    lit_fd(0, 1'b0);
    rst    = 1'b0;
    bcd_in = 16'h4321;
    dp_in  = 4'b0000;
    lit_digit(1, 4'b1110, 7'b0000001, 1'b1);

    // Second frame shows 4321 LSD first.
    lit_digit(17, 4'b1110, 7'b1001111, 1'b1);
    lit_digit(21, 4'b1101, 7'b0010010, 1'b1);
    lit_digit(25, 4'b1011, 7'b0000110, 1'b1);
    lit_digit(29, 4'b0111, 7'b1001100, 1'b1);
    lit_fd(31, 1'b0);
    lit_fd(32, 1'b1);
    lit_fd(33, 1'b0);

    // Non-BCD code and decimal point.
    bcd_in = 16'h00a7;
    dp_in  = 4'b0010;
    lit_digit(49, 4'b1110, 7'b0001111, 1'b1);
    lit_digit(53, 4'b1101, 7'b1111110, 1'b0);

    // Hold freezes 1234 while the input changes to 9999.
    bcd_in = 16'h1234;
    dp_in  = 4'b0000;
    lit_digit(65, 4'b1110, 7'b1001100, 1'b1);
    hold   = 1'b1;
    bcd_in = 16'h9999;
    lit_fd(80, 1'b0);
    lit_digit(81, 4'b1110, 7'b1001100, 1'b1);
    lit_digit(85, 4'b1101, 7'b0000110, 1'b1);
    lit_digit(89, 4'b1011, 7'b0010010, 1'b1);
    lit_digit(93, 4'b0111, 7'b1001111, 1'b1);
    lit_fd(96, 1'b0);
    hold = 1'b0;
    lit_digit(112, 4'b0111, 7'b1001111, 1'b1);
    chk("lit_capture_fd", {15'd0, frame_done}, 16'd1);
    lit_digit(113, 4'b1110, 7'b0000100, 1'b1);

    // Reset during the digit-2 slot.
    lit_digit(121, 4'b1011, 7'b0000100, 1'b1);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("mid_rst_an", {12'd0, an}, 16'h000f);
    chk("mid_rst_seg", {9'd0, seg}, 16'h007f);
    chk("mid_rst_fd", {15'd0, frame_done}, 16'd0);
    rst = 1'b0;
    lit_digit(1, 4'b1110, 7'b0000001, 1'b1);
    for (int kk = 2; kk < 16; kk++) lit_fd(kk, 1'b0);
    lit_fd(16, 1'b1);

    // Leading zeros.
    bcd_in = 16'h0050;
    lit_digit(33, 4'b1110, 7'b0000001, 1'b1);
    lit_digit(37, 4'b1101, 7'b0100100, 1'b1);
`ifdef LEADING_ZERO_BLANK_EN
    lit_digit(41, 4'b1011, 7'b1111111, 1'b1);
    lit_digit(45, 4'b0111, 7'b1111111, 1'b1);
`else
    lit_digit(41, 4'b1011, 7'b0000001, 1'b1);
    lit_digit(45, 4'b0111, 7'b0000001, 1'b1);
`endif
    bcd_in = 16'h0000;
    lit_digit(49, 4'b1110, 7'b0000001, 1'b1);
`ifdef LEADING_ZERO_BLANK_EN
    lit_digit(53, 4'b1101, 7'b1111111, 1'b1);
    lit_digit(57, 4'b1011, 7'b1111111, 1'b1);
    lit_digit(61, 4'b0111, 7'b1111111, 1'b1);
`else
    lit_digit(53, 4'b1101, 7'b0000001, 1'b1);
    lit_digit(57, 4'b1011, 7'b0000001, 1'b1);
    lit_digit(61, 4'b0111, 7'b0000001, 1'b1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
